// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional BURAQ_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

`ifdef BURAQ_FAST_MUL_EN
    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`endif

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      op_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic [XLEN:0]   acc_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] mcand_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Operand decode at acceptance
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, overflow, special;
    logic [XLEN-1:0] special_result;

    always_comb begin
        signed_a = op_i[2] ? ~op_i[0] : ~(op_i[1] & op_i[0]);
        signed_b = op_i[2] ? ~op_i[0] : ~op_i[1];
        sa       = signed_a & operand_a_i[XLEN-1];
        sb       = signed_b & operand_b_i[XLEN-1];
        mag_a    = sa ? -operand_a_i : operand_a_i;
        mag_b    = sb ? -operand_b_i : operand_b_i;
        b_zero   = (operand_b_i == '0);
        overflow = op_i[2] & ~op_i[0] & (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (operand_b_i == '1);
        special  = op_i[2] & (b_zero | overflow);
        if (b_zero) begin
            special_result = op_i[1] ? operand_a_i : '1;
        end else begin
            special_result = op_i[1] ? '0 : operand_a_i;
        end
    end

`ifdef BURAQ_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_prod_s;
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        fast_prod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_prod_s = (sa ^ sb) ? -fast_prod : fast_prod;
        fast_result = (op_i[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
    end
`else
    // Shift-add step: {acc, lo} holds the partial product, lo[0] is the current multiplier bit
    logic [XLEN:0]     mul_sum, mul_acc;
    logic [XLEN-1:0]   mul_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_result;

    always_comb begin
        mul_sum    = acc_q + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc    = {1'b0, mul_sum[XLEN:1]};
        mul_lo     = {mul_sum[0], lo_q[XLEN-1:1]};
        prod       = {mul_acc[XLEN-1:0], mul_lo};
        prod_s     = neg_q ? -prod : prod;
        mul_result = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
`endif

    // Restoring divide step: lo shifts the dividend out and the quotient in
    logic [XLEN:0]   div_shift, div_diff, div_acc;
    logic            div_ok;
    logic [XLEN-1:0] div_lo, quo_s, rem_s, div_result;

    always_comb begin
        div_shift  = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, mcand_q};
        div_ok     = ~div_diff[XLEN];
        div_acc    = div_ok ? div_diff : div_shift;
        div_lo     = {lo_q[XLEN-2:0], div_ok};
        quo_s      = neg_q ? -div_lo : div_lo;
        rem_s      = neg_rem_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
        div_result = op_q[1] ? rem_s : quo_s;
    end

    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            StIdle: stall_o = ~reset & start_i & ~flush_i;
`ifndef BURAQ_FAST_MUL_EN
            StMul:  stall_o = 1'b1;
`endif
            StDiv:  stall_o = 1'b1;
            StDone: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        op_q <= op_i[1:0];
                        if (special) begin
                            result_q <= special_result;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
`ifdef BURAQ_FAST_MUL_EN
                        end else if (!op_i[2]) begin
                            result_q <= fast_result;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
`endif
                        end else begin
                            acc_q     <= '0;
                            lo_q      <= op_i[2] ? mag_a : mag_b;
                            mcand_q   <= op_i[2] ? mag_b : mag_a;
                            neg_q     <= sa ^ sb;
                            neg_rem_q <= sa;
                            cnt_q     <= '0;
`ifdef BURAQ_FAST_MUL_EN
                            state_q   <= StDiv;
`else
                            state_q   <= op_i[2] ? StDiv : StMul;
`endif
                        end
                    end
                end
`ifndef BURAQ_FAST_MUL_EN
                StMul: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= mul_acc;
                        lo_q  <= mul_lo;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            result_q <= mul_result;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
`endif
                StDiv: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= div_acc;
                        lo_q  <= div_lo;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            result_q <= div_result;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
                // start_i here belongs to the instruction that is just leaving EX
                StDone: state_q <= StIdle;
            endcase
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + scoreboard bench for muldiv_sequencer; honours BURAQ_FAST_MUL_EN for mul latency.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_res_q[$];
    int          exp_lat_q[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .op_i        (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .flush_i     (flush),
        .stall_o     (stall),
        .done_o      (done),
        .result_o    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0]        ux, uy, p;
        logic signed [31:0] xs, ys, q;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        xs = x;
        ys = y;
        ref_model = '0;
        case (o)
            3'd0: begin p = sx * sy; ref_model = p[31:0];  end
            3'd1: begin p = sx * sy; ref_model = p[63:32]; end
            3'd2: begin p = sx * uy; ref_model = p[63:32]; end
            3'd3: begin p = ux * uy; ref_model = p[63:32]; end
            3'd4: begin
                if (y == 0) ref_model = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_model = x;
                else begin q = xs / ys; ref_model = q; end
            end
            3'd5: ref_model = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) ref_model = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_model = 0;
                else begin q = xs % ys; ref_model = q; end
            end
            default: ref_model = (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
`ifdef BURAQ_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return 33;
    endfunction

    // Issue one op starting at the next cycle; start is held until done like a stalled EX stage
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        logic        stall_bad;
        logic        got;
        logic [31:0] er;
        int          el;
        stall_bad = 1'b0;
        got       = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; op = o; a = x; b = y;
        exp_res_q.push_back(exp);
        exp_lat_q.push_back(exp_latency(o, x, y));
        @(negedge clk);
        if (stall !== 1'b1 || done !== 1'b0) stall_bad = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                er = exp_res_q.pop_front();
                el = exp_lat_q.pop_front();
                check({tag, " result"}, result, er);
                check({tag, " latency"}, cyc, el);
                check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
                got = 1'b1;
                break;
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
        end
        check({tag, " stall_window"}, {31'd0, stall_bad}, 32'd0);
        if (!got) begin
            check({tag, " timeout"}, {31'd0, got}, 32'd1);
            void'(exp_res_q.pop_front());
            void'(exp_lat_q.pop_front());
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic        bad;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b1; op = 3'd5; a = 32'd1; b = 32'd1; flush = 1'b0;
        #2;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("divu_z", 3'd5, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_z", 3'd6, 32'd5, 32'd0, 32'd5);
        run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Flush in cycle 10 of a DIV
        prev = 32'hFFFF_FFFF;
        bad  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        if (stall !== 1'b1) bad = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            if (cyc == 10) #1 flush = 1'b1;
            @(negedge clk);
            if (stall !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush pre_window", {31'd0, bad}, 32'd0);
        check("flush stall_c11", {31'd0, stall}, 32'd0);
        check("flush no_done", {31'd0, done}, 32'd0);
        check("flush result_kept", result, prev);
        run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 32'd3);

        // Reset in cycle 5 of a MULHU
        @(posedge clk);
        #1;
        start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 5; cyc++) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset stall", {31'd0, stall}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("postreset stall", {31'd0, stall}, 32'd0);
        check("postreset result", result, 32'd0);
        run_op("mul_6x7", 3'd0, 32'd6, 32'd7, 32'd42);

        // Random ops against the native-arithmetic model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = 32'hFFFF_FFFF;
            run_op("random", ro, ra, rb, ref_model(ro, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
